// File: rtl/tick_timer_pkg.sv
// Shared opcodes, channel state type and system clock constant for the tick timer.
package tick_timer_pkg;

  localparam int unsigned SYSCLK_HZ = 32'd100_000_000;

  localparam logic [2:0] OP_LOAD           = 3'd0;
  localparam logic [2:0] OP_START_ONESHOT  = 3'd1;
  localparam logic [2:0] OP_START_PERIODIC = 3'd2;
  localparam logic [2:0] OP_STOP           = 3'd3;
  localparam logic [2:0] OP_CLEAR_FLAG     = 3'd4;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Shared tick prescaler: while enabled, emits a one-cycle tick every prescale_i+1
// cycles; the counter is held at zero and the tick is low while disabled.
module tick_prescaler #(
  parameter int PRESCALE_W = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;
  logic                  tick_q;
  logic                  tick_d;

  // '>=' lets a lowered divisor wrap on the next edge instead of running on to overflow.
  always_comb begin
    if (!en_i) begin
      cnt_d  = {PRESCALE_W{1'b0}};
      tick_d = 1'b0;
    end else if (cnt_q >= prescale_i) begin
      cnt_d  = {PRESCALE_W{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + PRESCALE_W'(1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= {PRESCALE_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/tick_timer_ctrl.sv
// Multi-channel tick timer: one shared prescaler feeds NUM_CH countdown channels
// that expire in one-shot or periodic mode and raise sticky interrupt flags.
module tick_timer_ctrl
  import tick_timer_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 16,
  parameter  int PRESCALE_W = 20,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [2:0]            cfg_op,
  input  logic [CNT_W-1:0]      cfg_data,
  output logic                  tick_out,
  output logic [NUM_CH-1:0]     ch_busy,
  output logic [NUM_CH-1:0]     ch_expire,
  output logic [NUM_CH-1:0]     ch_flag,
  output logic                  irq
);

  logic any_run_s;

  assign any_run_s = |ch_busy;

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .en_i      (any_run_s),
    .prescale_i(prescale),
    .tick_o    (tick_out)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        state_q;
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] count_q;
    logic             periodic_q;
    logic             expire_q;
    logic             flag_q;
    logic             sel_s;
    logic             load_s;
    logic             start_s;
    logic             stop_s;
    logic             clear_s;
    logic             last_s;

    assign sel_s = cfg_we && (cfg_ch == CH_W'(g));

    always_comb begin
      load_s  = 1'b0;
      start_s = 1'b0;
      stop_s  = 1'b0;
      clear_s = 1'b0;
      if (sel_s) begin
        case (cfg_op)
          OP_LOAD:           load_s  = 1'b1;
          OP_START_ONESHOT,
          OP_START_PERIODIC: start_s = 1'b1;
          OP_STOP:           stop_s  = 1'b1;
          OP_CLEAR_FLAG:     clear_s = 1'b1;
          default:           load_s  = 1'b0;
        endcase
      end else begin
        load_s = 1'b0;
      end
    end

    // A START or STOP in the same cycle outranks the tick, so the final tick is lost.
    assign last_s = (state_q == CH_RUN) && tick_out && !start_s && !stop_s &&
                    (count_q <= CNT_W'(1));

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q    <= CH_IDLE;
        reload_q   <= {CNT_W{1'b0}};
        count_q    <= {CNT_W{1'b0}};
        periodic_q <= 1'b0;
        expire_q   <= 1'b0;
        flag_q     <= 1'b0;
      end else begin
        expire_q <= last_s;
        if (load_s) begin
          reload_q <= cfg_data;
        end
        case (state_q)
          CH_IDLE: begin
            if (start_s) begin
              state_q    <= CH_RUN;
              count_q    <= reload_q;
              periodic_q <= (cfg_op == OP_START_PERIODIC);
            end
          end
          CH_RUN: begin
            if (start_s) begin
              count_q    <= reload_q;
              periodic_q <= (cfg_op == OP_START_PERIODIC);
            end else if (stop_s) begin
              state_q <= CH_IDLE;
            end else if (last_s) begin
              if (periodic_q) begin
                count_q <= reload_q;
              end else begin
                count_q <= {CNT_W{1'b0}};
                state_q <= CH_IDLE;
              end
            end else if (tick_out) begin
              count_q <= count_q - CNT_W'(1);
            end
          end
          default: state_q <= CH_IDLE;
        endcase
        if (last_s) begin
          flag_q <= 1'b1;
        end else if (clear_s) begin
          flag_q <= 1'b0;
        end
      end
    end

    assign ch_busy[g]   = (state_q == CH_RUN);
    assign ch_expire[g] = expire_q;
    assign ch_flag[g]   = flag_q;
  end

  assign irq = |ch_flag;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Self-checking bench for tick_timer_ctrl: directed scenarios plus random commands,
// every cycle compared against a tick-counting reference model.
module tb_tick_timer_ctrl;

  localparam int NUM_CH     = 3;
  localparam int CNT_W      = 16;
  localparam int PRESCALE_W = 20;
  localparam int CH_W       = 2;

  localparam logic [2:0] C_LOAD   = 3'd0;
  localparam logic [2:0] C_ONE    = 3'd1;
  localparam logic [2:0] C_PER    = 3'd2;
  localparam logic [2:0] C_STOP   = 3'd3;
  localparam logic [2:0] C_CLEAR  = 3'd4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [PRESCALE_W-1:0] prescale;
  logic                  cfg_we;
  logic [CH_W-1:0]       cfg_ch;
  logic [2:0]            cfg_op;
  logic [CNT_W-1:0]      cfg_data;
  logic                  tick_out;
  logic [NUM_CH-1:0]     ch_busy;
  logic [NUM_CH-1:0]     ch_expire;
  logic [NUM_CH-1:0]     ch_flag;
  logic                  irq;

  tick_timer_ctrl #(
    .NUM_CH    (NUM_CH),
    .CNT_W     (CNT_W),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .prescale (prescale),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_op   (cfg_op),
    .cfg_data (cfg_data),
    .tick_out (tick_out),
    .ch_busy  (ch_busy),
    .ch_expire(ch_expire),
    .ch_flag  (ch_flag),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: cycles since last tick, and ticks remaining until expiry per channel.
  int m_since;
  bit m_tick;
  bit m_run  [NUM_CH];
  bit m_per  [NUM_CH];
  bit m_flag [NUM_CH];
  bit m_exp  [NUM_CH];
  int m_left [NUM_CH];
  int m_rel  [NUM_CH];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit any;
    bit tick_seen;
    tick_seen = m_tick;
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) any |= m_run[i];
    if (!reset) begin
      m_since = 0;
      m_tick  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_run[i] = 1'b0; m_per[i] = 1'b0; m_flag[i] = 1'b0;
        m_exp[i] = 1'b0; m_left[i] = 0;   m_rel[i]  = 0;
      end
    end else begin
      if (!any) begin
        m_since = 0;
        m_tick  = 1'b0;
      end else if (m_since >= int'(prescale)) begin
        m_since = 0;
        m_tick  = 1'b1;
      end else begin
        m_since = m_since + 1;
        m_tick  = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        bit sel;
        int ticks_needed;
        sel = cfg_we && (int'(cfg_ch) == i);
        ticks_needed = (m_rel[i] == 0) ? 1 : m_rel[i];
        m_exp[i] = 1'b0;
        if (sel && cfg_op == C_LOAD) m_rel[i] = int'(cfg_data);
        if (sel && (cfg_op == C_ONE || cfg_op == C_PER)) begin
          m_left[i] = ticks_needed;
          m_run[i]  = 1'b1;
          m_per[i]  = (cfg_op == C_PER);
        end else if (sel && cfg_op == C_STOP) begin
          m_run[i] = 1'b0;
        end else if (m_run[i] && tick_seen) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin
            m_exp[i]  = 1'b1;
            m_flag[i] = 1'b1;
            if (m_per[i]) m_left[i] = ticks_needed;
            else          m_run[i]  = 1'b0;
          end
        end
        if (sel && cfg_op == C_CLEAR && !m_exp[i]) m_flag[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_busy, e_exp, e_flag;
    for (int i = 0; i < NUM_CH; i++) begin
      e_busy[i] = m_run[i];
      e_exp[i]  = m_exp[i];
      e_flag[i] = m_flag[i];
    end
    check_val("tick_out", 32'(tick_out), 32'(m_tick));
    check_val("ch_busy", 32'(ch_busy), 32'(e_busy));
    check_val("ch_expire", 32'(ch_expire), 32'(e_exp));
    check_val("ch_flag", 32'(ch_flag), 32'(e_flag));
    check_val("irq", 32'(irq), 32'(|e_flag));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic cmd(input logic [2:0] op, input int ch, input int data);
    cfg_we   = 1'b1;
    cfg_op   = op;
    cfg_ch   = CH_W'(ch);
    cfg_data = CNT_W'(data);
    cycle();
    cfg_we   = 1'b0;
  endtask

  initial begin
    int t0, r0, s0, s1, first_tick, exp_at, n_ticks, n_exp, n_common, ch1_at, ch1_cnt;
    int ch0_at[$];

    reset = 1'b0; prescale = 20'd5; cfg_we = 1'b1;
    cfg_op = C_PER; cfg_ch = 2'd0; cfg_data = 16'd2;
    m_since = 0; m_tick = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 1'b0; m_per[i] = 1'b0; m_flag[i] = 1'b0;
      m_exp[i] = 1'b0; m_left[i] = 0;   m_rel[i]  = 0;
    end

    // Reset with a command pending, then stay idle.
    idle(3);
    reset = 1'b1; cfg_we = 1'b0;
    n_ticks = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (tick_out) n_ticks++;
    end
    check_val("idle_ticks", n_ticks, 0);
    check_val("idle_outputs", 32'({ch_busy, ch_expire, ch_flag, irq}), 32'd0);

    // One-shot, prescale 3, reload 5.
    prescale = 20'd3;
    cmd(C_LOAD, 0, 5);
    cmd(C_ONE, 0, 0);
    t0 = cyc; first_tick = -1; exp_at = -1; n_ticks = 0; n_exp = 0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (tick_out && cyc <= t0 + 20) begin
        n_ticks++;
        if (first_tick < 0) first_tick = cyc - t0;
      end
      if (ch_expire[0]) begin
        n_exp++;
        if (exp_at < 0) exp_at = cyc - t0;
      end
    end
    check_val("os_first_tick", first_tick, 4);
    check_val("os_tick_count", n_ticks, 5);
    check_val("os_expire_at", exp_at, 21);
    check_val("os_expire_count", n_exp, 1);
    check_val("os_busy_flag_irq", 32'({ch_busy[0], ch_flag[0], irq}), 32'b011);
    cmd(C_CLEAR, 0, 0);

    // Periodic ch0 (reload 2) and one-shot ch1 (reload 3) with prescale 1.
    prescale = 20'd1;
    cmd(C_LOAD, 0, 2);
    cmd(C_LOAD, 1, 3);
    cmd(C_PER, 0, 0);
    s0 = cyc;
    idle(2);
    cmd(C_ONE, 1, 0);
    s1 = cyc; n_common = 0; ch1_at = -1; ch1_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (ch_expire[0]) ch0_at.push_back(cyc - s0);
      if (ch_expire[1]) begin
        ch1_cnt++;
        if (ch1_at < 0) ch1_at = cyc - s1;
      end
      if (ch_expire[0] && ch_expire[1]) n_common++;
    end
    check_val("per_first", ch0_at[0], 5);
    check_val("per_count", ch0_at.size(), 8);
    for (int i = 1; i < ch0_at.size(); i++) check_val("per_gap", ch0_at[i] - ch0_at[i-1], 4);
    check_val("ch1_expire_at", ch1_at, 6);
    check_val("ch1_expire_count", ch1_cnt, 1);
    check_val("common_expire", 32'(n_common > 0), 32'd1);
    cmd(C_STOP, 0, 0);
    idle(3);
    cmd(C_CLEAR, 0, 0);
    cmd(C_CLEAR, 1, 0);

    // STOP on the final-tick cycle suppresses expiry.
    prescale = 20'd3;
    cmd(C_LOAD, 0, 2);
    cmd(C_ONE, 0, 0);
    idle(8);
    cmd(C_STOP, 0, 0);
    n_exp = 0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (ch_expire[0]) n_exp++;
    end
    check_val("stop_final_expire", n_exp, 0);
    check_val("stop_final_flag", 32'(ch_flag[0]), 32'd0);

    // CLEAR_FLAG in the expiry cycle loses to the set.
    cmd(C_LOAD, 0, 1);
    cmd(C_ONE, 0, 0);
    idle(4);
    cmd(C_CLEAR, 0, 0);
    check_val("clr_vs_set_expire", 32'(ch_expire[0]), 32'd1);
    idle(1);
    check_val("clr_vs_set_flag", 32'(ch_flag[0]), 32'd1);
    cmd(C_CLEAR, 0, 0);

    // Restart lands on a tick cycle; count returns to reload.
    prescale = 20'd1;
    cmd(C_LOAD, 0, 4);
    cmd(C_ONE, 0, 0);
    idle(4);
    cmd(C_ONE, 0, 0);
    r0 = cyc; exp_at = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (ch_expire[0] && exp_at < 0) exp_at = cyc - r0;
    end
    check_val("restart_expire_at", exp_at, 8);

    // Reload 0 expires after one tick.
    prescale = 20'd2;
    cmd(C_LOAD, 2, 0);
    cmd(C_ONE, 2, 0);
    t0 = cyc; exp_at = -1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (ch_expire[2] && exp_at < 0) exp_at = cyc - t0;
    end
    check_val("reload0_expire_at", exp_at, 4);

    // prescale 0 ticks every cycle.
    prescale = 20'd0;
    cmd(C_LOAD, 0, 3);
    cmd(C_PER, 0, 0);
    n_ticks = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (tick_out) n_ticks++;
    end
    check_val("prescale0_ticks", n_ticks, 10);
    cmd(C_STOP, 0, 0);
    idle(3);

    // Lowering prescale below the running count wraps on the next edge.
    prescale = 20'd100;
    cmd(C_PER, 0, 0);
    n_ticks = 0;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (tick_out) n_ticks++;
    end
    check_val("drop_no_early_tick", n_ticks, 0);
    prescale = 20'd2;
    cycle();
    check_val("drop_tick", 32'(tick_out), 32'd1);
    cmd(C_STOP, 0, 0);
    idle(3);

    // Out-of-range channel index is ignored.
    cmd(C_LOAD, NUM_CH, 7);
    cmd(C_ONE, NUM_CH, 0);
    check_val("bad_ch_busy", 32'(ch_busy), 32'd0);
    idle(3);
    check_val("bad_ch_tick", 32'(tick_out), 32'd0);

    // Reset mid-run clears everything, even with a command pending.
    prescale = 20'd1;
    cmd(C_LOAD, 1, 1);
    cmd(C_PER, 0, 0);
    cmd(C_PER, 1, 0);
    idle(4);
    reset = 1'b0; cfg_we = 1'b1; cfg_op = C_ONE; cfg_ch = 2'd2;
    cycle();
    reset = 1'b1; cfg_we = 1'b0;
    check_val("midrun_reset", 32'({tick_out, ch_busy, ch_expire, ch_flag, irq}), 32'd0);

    // Random command stream against the model.
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 63) == 0) prescale = PRESCALE_W'($urandom_range(0, 6));
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_op   = 3'($urandom_range(0, 7));
      cfg_ch   = CH_W'($urandom_range(0, 3));
      cfg_data = CNT_W'($urandom_range(0, 6));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tick_timer_ctrl.md
Name: tick_timer_ctrl

Overview:
Multi-channel timer controller built around one shared programmable tick prescaler on the 100 MHz system clock. The prescaler is the single divided-tick resource. Each channel counts prescaler ticks down from its own reload value and signals expiry in one-shot or periodic mode. It sits between the CPU-side peripheral write port and the interrupt logic, and replaces per-consumer fixed-frequency tick generators.

Parameters:
NUM_CH, 4, number of timer channels (>=1)
CNT_W, 16, width of channel reload/count registers
PRESCALE_W, 20, width of prescaler divisor input
CH_W, $clog2(NUM_CH) (min 1), channel index width (derived localparam)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset (0 = reset)
prescale  input  PRESCALE_W  divisor minus one; tick period = prescale+1 cycles
cfg_we  input  1  config command valid, sampled every rising edge, no backpressure
cfg_ch  input  CH_W  target channel
cfg_op  input  3  0 LOAD, 1 START_ONESHOT, 2 START_PERIODIC, 3 STOP, 4 CLEAR_FLAG, 5-7 ignored
cfg_data  input  CNT_W  reload value for LOAD
tick_out  output  1  registered shared tick pulse, 1 cycle wide
ch_busy  output  NUM_CH  channel in RUN state
ch_expire  output  NUM_CH  registered 1-cycle expiry pulse per channel
ch_flag  output  NUM_CH  sticky expiry flag per channel
irq  output  1  OR-reduction of ch_flag

Behaviour:
- Reset (reset==0 at an edge): prescaler counter, all reload/count registers, states, tick_out, ch_busy, ch_expire, ch_flag and irq go to 0. Reset overrides any cfg command in the same cycle, including mid-count.
- Prescaler runs only while any channel is RUN. Otherwise its counter is held at 0 and tick_out is 0.
- While running, the counter increments each cycle. When counter >= prescale, the counter returns to 0 and tick_out is high the next cycle.
- A '>=' compare ensures a lowered prescale wraps immediately.
- prescale==0 gives tick_out high every cycle while running.
- From an idle prescaler, the first tick_out occurs prescale+1 cycles after the START edge.
- A channel started while others run sees a partial first tick period (documented jitter, up to prescale+1 cycles).
- Channel FSM has states IDLE and RUN. ch_busy = (state==RUN).
- LOAD writes the reload register only. A running channel keeps its current count; the new reload is used at the next reload or start.
- START_*: count <= reload, mode latched, state <= RUN, from either state. START on a running channel is a restart.
- STOP: state <= IDLE and count is held. STOP on an idle channel is a no-op.
- On each tick_out cycle while RUN:
  - if count <= 1: ch_expire high next cycle, ch_flag set. Periodic reloads count and stays RUN. One-shot goes to IDLE.
  - otherwise count decrements by 1.
- Reload N gives expiry after N ticks. N=0 behaves as N=1.
- Simultaneous events, same channel same cycle:
  - STOP vs final tick: STOP wins, no expire, no flag.
  - START vs tick: START wins, count = reload, tick not applied.
  - CLEAR_FLAG vs flag set: set wins.
- cfg_ch >= NUM_CH: command ignored.
- Only one command per cycle. Channels are updated independently, and any number may expire on the same tick.
- Arithmetic is unsigned; the count never underflows below 0.

Decomposition:
- Shared package tick_timer_pkg: cfg_op opcode constants, channel state enum (IDLE/RUN), and the SYSCLK frequency constant shared with existing clock generation.
- One sub-module, tick_prescaler: enable, prescale input, registered tick output, with the counter/compare logic above.
- Channel logic lives in a generate loop inside tick_timer_ctrl.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with cfg_we active, then release. All outputs are 0, and tick_out stays 0 for 50 cycles with no channel started.
- One-shot timing: prescale=3; LOAD ch0 5, START_ONESHOT ch0 at edge T.
  - tick_out high at T+4, T+8, ..., T+20.
  - ch_expire[0] high only at T+21.
  - ch_busy[0] is 0 from T+21; ch_flag[0]=1 and irq=1.
- Periodic, two channels: prescale=1; ch0 reload 2 periodic, ch1 reload 3 one-shot, both started.
  - ch0 expires every 4 cycles repeatedly.
  - ch1 expires once, 6 cycles after its first tick period begins.
  - At a common tick, both ch_expire bits are high in the same cycle.
- Collisions:
  - STOP ch0 on its final-tick cycle: no ch_expire and flag stays 0.
  - CLEAR_FLAG in the same cycle as expiry: flag reads 1 afterwards.
  - Restart mid-count: count returns to reload.
- Boundaries:
  - reload 0 expires after 1 tick.
  - prescale=0 gives a tick every cycle.
  - Drop prescale from 100 to 2 while the counter is at 50: the tick follows within 1 cycle.
  - cfg_ch=NUM_CH is ignored.
  - reset=0 mid-run clears everything.
